vga_sync_core: RTL and testbench

Pixel-timing and output stage for the 640x480@60 Hz display path. It consumes the composited 8-bit colour produced by the image/text colour mux and drives the VGA port. It generates the horizontal/vertical counters that the image and text stages use as pixel addresses. It delays sync and blanking to match the colour pipeline latency, so the picture lands on the correct pixel.

---
 rtl/vga_pkg.sv | 56 +++++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_sync_core.sv | 134 +++++++++++++
 tb/tb_vga_sync_core.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, sync-window bounds, delay-line flag layout and
// the colour-bar table used when VGA_TEST_PATTERN_EN is defined.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Sync windows are [START, END): END is the first counter value back high.
  localparam int unsigned VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
  localparam int unsigned VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } vga_flags_t;

  localparam vga_flags_t VGA_FLAGS_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  function automatic logic [7:0] vga_tp_colour(input logic [2:0] bar);
    logic [7:0] c;
    case (bar)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'hFC;
      3'd2:    c = 8'h1F;
      3'd3:    c = 8'h1C;
      3'd4:    c = 8'hE3;
      3'd5:    c = 8'hE0;
      3'd6:    c = 8'h03;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Bar number = how many bar boundaries the column has passed (saturates at 7).
  function automatic logic [2:0] vga_bar_index(input logic [9:0] col, input int unsigned bar_w);
    logic [2:0] idx;
    idx = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (32'(col) >= k * bar_w) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enabled shift register of DEPTH stages; reset loads every stage with RESET_VAL.
module vga_delay_line #(
  parameter int unsigned     WIDTH     = 1,
  parameter int unsigned     DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
    end else if (en) begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_core.sv
// VGA pixel counters, pixel addresses and latency-matched sync/blank/colour output.
// Optional macro VGA_TEST_PATTERN_EN replaces colour_in with eight colour bars.
module vga_sync_core
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic [7:0] colour_in,
  output logic [7:0] colour_out,
  output logic       hs,
  output logic       vs,
  output logic [9:0] addr_h,
  output logic [8:0] addr_v,
  output logic       video_on,
  output logic       refresh
);

  localparam logic [9:0] L_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] L_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] L_HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] L_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] L_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] L_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] L_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] L_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h_cnt, r_v_cnt;
  logic [7:0] r_colour;
  logic       r_hs, r_vs, r_video_on, r_refresh;
  logic [9:0] r_addr_h;
  logic [8:0] r_addr_v;

  logic       w_h_wrap;
  logic [9:0] w_h_nxt, w_v_nxt;
  logic       w_act_nxt;
  vga_flags_t w_raw, w_tail;
  logic [7:0] w_pix;

  assign w_h_wrap  = (r_h_cnt == L_H_LAST);
  assign w_h_nxt   = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
  assign w_v_nxt   = !w_h_wrap ? r_v_cnt :
                     (r_v_cnt == L_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
  assign w_act_nxt = (w_h_nxt < L_H_ACT) && (w_v_nxt < L_V_ACT);

  assign w_raw.active = (r_h_cnt < L_H_ACT) && (r_v_cnt < L_V_ACT);
  assign w_raw.hs     = !((r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END));
  assign w_raw.vs     = !((r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END));

  // Flags from the counters enter here and meet colour_in at the tail, one
  // output register before the port: total lag PIPE_LAT+1 ticks.
  vga_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_LAT),
    .RESET_VAL(VGA_FLAGS_IDLE)
  ) u_flag_dly (
    .clk  (clk),
    .reset(reset),
    .en   (pix_en),
    .d    (w_raw),
    .q    (w_tail)
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [2:0] w_bar, w_bar_tail;
  logic       w_unused_colour;

  assign w_bar = vga_bar_index(r_h_cnt, BAR_W);

  vga_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_LAT),
    .RESET_VAL(3'd0)
  ) u_bar_dly (
    .clk  (clk),
    .reset(reset),
    .en   (pix_en),
    .d    (w_bar),
    .q    (w_bar_tail)
  );

  assign w_pix           = vga_tp_colour(w_bar_tail);
  assign w_unused_colour = ^colour_in;
`else
  assign w_pix = colour_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt    <= 10'd0;
      r_v_cnt    <= 10'd0;
      r_addr_h   <= 10'd0;
      r_addr_v   <= 9'd0;
      r_video_on <= 1'b0;
      r_colour   <= 8'h00;
      r_hs       <= 1'b1;
      r_vs       <= 1'b1;
      r_refresh  <= 1'b0;
    end else begin
      r_refresh <= 1'b0;
      if (pix_en) begin
        r_h_cnt    <= w_h_nxt;
        r_v_cnt    <= w_v_nxt;
        r_addr_h   <= w_act_nxt ? w_h_nxt : 10'd0;
        r_addr_v   <= w_act_nxt ? 9'(w_v_nxt) : 9'd0;
        r_video_on <= w_act_nxt;
        r_colour   <= w_tail.active ? w_pix : 8'h00;
        r_hs       <= w_tail.hs;
        r_vs       <= w_tail.vs;
        r_refresh  <= w_h_wrap && (r_v_cnt == L_V_ACT - 10'd1);
      end
    end
  end

  assign colour_out = r_colour;
  assign hs         = r_hs;
  assign vs         = r_vs;
  assign addr_h     = r_addr_h;
  assign addr_v     = r_addr_v;
  assign video_on   = r_video_on;
  assign refresh    = r_refresh;

endmodule

// File: tb/tb_vga_sync_core.sv
// Bench for vga_sync_core: full-width lines with a shortened frame so whole
// frames fit in a short run; port words are predicted by an independent model.
module tb_vga_sync_core;

  localparam int P   = 2;
  localparam int HA  = 640;
  localparam int HT  = 800;
  localparam int HS0 = 656;
  localparam int HS1 = 752;
  localparam int VA  = 6;
  localparam int VT  = 12;
  localparam int VS0 = 8;
  localparam int VS1 = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic [7:0] colour_in = 8'h00;
  logic [7:0] colour_out;
  logic       hs, vs, video_on, refresh;
  logic [9:0] addr_h;
  logic [8:0] addr_v;

  // clock / reset block: reset is driven per step by the segment table
  always #5 clk = ~clk;

  vga_sync_core #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(VA),  .V_FP(2),  .V_SYNC(2),  .V_BP(2),
    .PIPE_LAT(P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .colour_in (colour_in),
    .colour_out(colour_out),
    .hs        (hs),
    .vs        (vs),
    .addr_h    (addr_h),
    .addr_v    (addr_v),
    .video_on  (video_on),
    .refresh   (refresh)
  );

  typedef struct {
    bit act;
    bit hs;
    bit vs;
    int col;
  } flags_t;

  typedef struct {
    bit rst;
    int div;
    int ticks;
    int idle;
    int exp_rf;
    int exp_hs_low;
    int exp_vs_low;
  } seg_t;

  flags_t      fl [P+1];
  logic [7:0]  cin_hist [P+1];
  logic [7:0]  tp_tab [8];
  logic [30:0] exp_q [$];
  logic [30:0] last_exp;
  int          m_h, m_v;
  int          n_checks = 0;
  int          n_pass = 0;
  int          ticks_rel, t656, last_fall;
  bit          fall_valid, first_tick, rf_pending, prev_hs;
  int          seg_rf, seg_hs, seg_vs;
  seg_t        segs [8];

  function automatic flags_t mk(input int h, input int v);
    flags_t f;
    f.act = (h < HA) && (v < VA);
    f.hs  = !(h >= HS0 && h < HS1);
    f.vs  = !(v >= VS0 && v < VS1);
    f.col = h;
    return f;
  endfunction

  function automatic logic [30:0] pk(input logic [7:0] c, input bit h, input bit v,
                                     input int ah, input int av, input bit von, input bit rf);
    logic [9:0] a10;
    logic [8:0] a9;
    a10 = 10'(ah);
    a9  = 9'(av);
    return {c, h, v, a10, a9, von, rf};
  endfunction

  function automatic logic [7:0] exp_colour(input flags_t e);
    logic [7:0] c;
    int         bar;
    logic [31:0] col;
    col = 32'(e.col);
    bar = e.col / (HA / 8);
    if (bar > 7) bar = 7;
`ifdef VGA_TEST_PATTERN_EN
    c = tp_tab[bar];
`else
    c = col[7:0];
`endif
    return e.act ? c : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", name, got, exp, ticks_rel);
  endtask

  task automatic model_reset();
    m_h = 0;
    m_v = 0;
    fl[0] = mk(0, 0);
    for (int k = 1; k <= P; k++) fl[k] = '{act: 1'b0, hs: 1'b1, vs: 1'b1, col: 0};
  endtask

  // driver: one clk of stimulus; expected port word queued before the edge
  task automatic step(input bit rst, input bit en);
    logic [30:0] exp, got;
    flags_t      e;
    bit          rf;
    reset  = rst;
    pix_en = en;
    e      = fl[P];
    if (rst) begin
      model_reset();
      exp = pk(8'h00, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    end else if (en) begin
      rf = (m_h == HT - 1) && (m_v == VA - 1);
      m_h++;
      if (m_h == HT) begin
        m_h = 0;
        m_v++;
        if (m_v == VT) m_v = 0;
      end
      for (int k = P; k > 0; k--) fl[k] = fl[k-1];
      fl[0] = mk(m_h, m_v);
      exp = pk(exp_colour(e), e.hs, e.vs, fl[0].act ? m_h : 0, fl[0].act ? m_v : 0,
               fl[0].act, rf);
    end else begin
      exp = last_exp;
    end
    last_exp = {exp[30:1], 1'b0};
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    got = {colour_out, hs, vs, addr_h, addr_v, video_on, refresh};
    check("port_word", {1'b0, got}, {1'b0, exp_q.pop_front()});
`ifdef VGA_TEST_PATTERN_EN
    if (en && !rst && e.act && e.col == 85) check("tp_x85", {24'd0, colour_out}, 32'hFC);
`endif
    if (rst) begin
      for (int k = 0; k <= P; k++) cin_hist[k] = 8'h00;
    end else if (en) begin
      for (int k = P; k > 0; k--) cin_hist[k] = cin_hist[k-1];
      cin_hist[0] = addr_h[7:0];
    end
    colour_in = cin_hist[P];
  endtask

  task automatic run_seg(input seg_t s);
    seg_rf = 0;
    seg_hs = 0;
    seg_vs = 0;
    for (int t = 0; t < s.ticks; t++) begin
      if (s.rst) begin
        step(1'b1, 1'b1);
        ticks_rel  = 0;
        fall_valid = 1'b0;
        first_tick = 1'b1;
        rf_pending = 1'b1;
        prev_hs    = 1'b1;
      end else begin
        for (int d = 0; d < s.div - 1; d++) begin
          step(1'b0, 1'b0);
          if (refresh) seg_rf++;
        end
        step(1'b0, 1'b1);
        ticks_rel++;
        if (first_tick) begin
          check("first_addr_h", {22'd0, addr_h}, 32'd1);
          first_tick = 1'b0;
        end
        if (m_h == HS0) t656 = ticks_rel;
        if (refresh) begin
          seg_rf++;
          if (rf_pending) check("refresh_latency", ticks_rel, VA * HT);
          rf_pending = 1'b0;
        end
        if (!hs) seg_hs++;
        if (!vs) seg_vs++;
        if (prev_hs && !hs) begin
          check("hs_fall_lag", ticks_rel - t656, P + 1);
          if (fall_valid) check("hs_period", ticks_rel - last_fall, HT);
          last_fall  = ticks_rel;
          fall_valid = 1'b1;
        end
        prev_hs = hs;
      end
    end
    for (int i = 0; i < s.idle; i++) begin
      step(1'b0, 1'b0);
      if (refresh) seg_rf++;
    end
    check("seg_refresh_count", seg_rf, s.exp_rf);
    check("seg_hs_low_ticks", seg_hs, s.exp_hs_low);
    check("seg_vs_low_ticks", seg_vs, s.exp_vs_low);
  endtask

  initial begin
    tp_tab = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    for (int k = 0; k <= P; k++) cin_hist[k] = 8'h00;
    model_reset();
    last_exp  = '0;
    ticks_rel = 0;
    t656      = 0;
    last_fall = 0;
    prev_hs   = 1'b1;

    //             rst div ticks idle rf hs_low vs_low
    segs[0] = '{1'b1, 1,    3,   0, 0,    0,    0};  // reset held with pix_en high
    segs[1] = '{1'b0, 4,  800,   0, 0,   96,    0};  // one line, pix_en every 4th clk
    segs[2] = '{1'b0, 1, 8800,   0, 1, 1056, 1600};  // rest of frame 0
    segs[3] = '{1'b0, 1,  300,  50, 0,    0,    0};  // mid-line pause
    segs[4] = '{1'b0, 1, 2400,   0, 0,  288,    0};  // resume into line 3
    segs[5] = '{1'b1, 1,    2,   0, 0,    0,    0};  // reset mid-frame
    segs[6] = '{1'b0, 1, 4800,   0, 1,  576,    0};  // up to refresh
    segs[7] = '{1'b0, 2, 4800,   0, 0,  576, 1600};  // remainder of frame

    for (int s = 0; s < 8; s++) run_seg(segs[s]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
